// File: rtl/buffer_command_frontend.sv
// Push-button command front-end: synchronizes and debounces four buttons plus the key/data
// switches, and turns each accepted press into one registered single-cycle buffer command.
module buffer_command_frontend #(
    parameter int DATA_WIDTH      = 8,
    parameter int KEY_WIDTH       = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                  clk,
    input  logic                  async_nreset,
    input  logic                  btn_load,
    input  logic                  btn_incr,
    input  logic                  btn_clr,
    input  logic                  btn_read,
    input  logic [KEY_WIDTH-1:0]  sw_key,
    input  logic [DATA_WIDTH-1:0] sw_data,
    input  logic                  cmd_enable,
    output logic [1:0]            ctrl,
    output logic [KEY_WIDTH-1:0]  key,
    output logic [DATA_WIDTH-1:0] data_in,
    output logic                  start_reading,
    output logic                  busy
);

    localparam int NUM_BTN  = 4;
    localparam int BTN_LOAD = 0;
    localparam int BTN_INCR = 1;
    localparam int BTN_CLR  = 2;
    localparam int BTN_READ = 3;
    localparam int SYNC_W   = NUM_BTN + KEY_WIDTH + DATA_WIDTH;
    localparam int CNT_W    = $clog2(DEBOUNCE_CYCLES);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] CTRL_NONE = 2'd0;
    localparam logic [1:0] CTRL_LOAD = 2'd1;
    localparam logic [1:0] CTRL_INCR = 2'd2;
    localparam logic [1:0] CTRL_CLR  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RELEASE
    } state_t;

    // ------------------------------------------------------------------
    // Two-flop synchronizer over buttons and switches as one vector
    // ------------------------------------------------------------------
    logic [SYNC_W-1:0]     raw_in;
    logic [SYNC_W-1:0]     sync_meta_q;
    logic [SYNC_W-1:0]     sync_q;
    logic [NUM_BTN-1:0]    btn_sync;
    logic [KEY_WIDTH-1:0]  key_sync;
    logic [DATA_WIDTH-1:0] data_sync;

    assign raw_in = {sw_data, sw_key, btn_read, btn_clr, btn_incr, btn_load};

    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            sync_meta_q <= '0;
            sync_q      <= '0;
        end else begin
            sync_meta_q <= raw_in;
            sync_q      <= sync_meta_q;
        end
    end

    assign btn_sync  = sync_q[NUM_BTN-1:0];
    assign key_sync  = sync_q[NUM_BTN +: KEY_WIDTH];
    assign data_sync = sync_q[NUM_BTN+KEY_WIDTH +: DATA_WIDTH];

    // ------------------------------------------------------------------
    // Per-button debounce: a level change is accepted only after it has
    // persisted for DEBOUNCE_CYCLES consecutive cycles.
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] btn_deb;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_debounce
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             level_q;
            logic             level_d;

            always_comb begin
                cnt_d   = '0;
                level_d = level_q;
                if (btn_sync[gi] != level_q) begin
                    if (cnt_q == CNT_LAST) begin
                        level_d = ~level_q;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            always_ff @(posedge clk or negedge async_nreset) begin
                if (!async_nreset) begin
                    cnt_q   <= '0;
                    level_q <= 1'b0;
                end else begin
                    cnt_q   <= cnt_d;
                    level_q <= level_d;
                end
            end

            assign btn_deb[gi] = level_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Command selection: READ > CLR > LOAD > INCR; losers are dropped.
    // ------------------------------------------------------------------
    logic       any_btn;
    logic [1:0] cmd_ctrl;
    logic       cmd_read;

    assign any_btn = |btn_deb;

    always_comb begin
        cmd_ctrl = CTRL_NONE;
        cmd_read = 1'b0;
        if (btn_deb[BTN_READ]) begin
            cmd_read = 1'b1;
        end else if (btn_deb[BTN_CLR]) begin
            cmd_ctrl = CTRL_CLR;
        end else if (btn_deb[BTN_LOAD]) begin
            cmd_ctrl = CTRL_LOAD;
        end else if (btn_deb[BTN_INCR]) begin
            cmd_ctrl = CTRL_INCR;
        end
    end

    // ------------------------------------------------------------------
    // Issue FSM with registered outputs
    // ------------------------------------------------------------------
    state_t                state_q;
    logic [1:0]            ctrl_q;
    logic                  start_q;
    logic [KEY_WIDTH-1:0]  key_q;
    logic [DATA_WIDTH-1:0] data_q;

    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            state_q <= ST_IDLE;
            ctrl_q  <= CTRL_NONE;
            start_q <= 1'b0;
            key_q   <= '0;
            data_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_btn) begin
                        // A disabled press is still consumed so it cannot fire later.
                        if (cmd_enable) begin
                            state_q <= ST_ISSUE;
                            ctrl_q  <= cmd_ctrl;
                            start_q <= cmd_read;
                            key_q   <= key_sync;
                            data_q  <= data_sync;
                        end else begin
                            state_q <= ST_WAIT_RELEASE;
                        end
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_WAIT_RELEASE;
                    ctrl_q  <= CTRL_NONE;
                    start_q <= 1'b0;
                end
                ST_WAIT_RELEASE: begin
                    if (!any_btn) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ctrl_q  <= CTRL_NONE;
                    start_q <= 1'b0;
                end
            endcase
        end
    end

    assign ctrl          = ctrl_q;
    assign start_reading = start_q;
    assign key           = key_q;
    assign data_in       = data_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_buffer_command_frontend.sv
// Scoreboard bench for buffer_command_frontend: a cycle-level reference model predicts each
// command pulse and the held outputs; a negedge monitor compares whatever the design presents.
module tb_buffer_command_frontend;

    localparam int DW = 8;
    localparam int KW = 4;
    localparam int DB = 4;

    logic          clk = 1'b0;
    logic          async_nreset = 1'b0;
    logic          btn_load = 1'b0;
    logic          btn_incr = 1'b0;
    logic          btn_clr  = 1'b0;
    logic          btn_read = 1'b0;
    logic [KW-1:0] sw_key   = '0;
    logic [DW-1:0] sw_data  = '0;
    logic          cmd_enable = 1'b1;
    logic [1:0]    ctrl;
    logic [KW-1:0] key;
    logic [DW-1:0] data_in;
    logic          start_reading;
    logic          busy;

    always #5 clk = ~clk;

    buffer_command_frontend #(
        .DATA_WIDTH     (DW),
        .KEY_WIDTH      (KW),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk          (clk),
        .async_nreset (async_nreset),
        .btn_load     (btn_load),
        .btn_incr     (btn_incr),
        .btn_clr      (btn_clr),
        .btn_read     (btn_read),
        .sw_key       (sw_key),
        .sw_data      (sw_data),
        .cmd_enable   (cmd_enable),
        .ctrl         (ctrl),
        .key          (key),
        .data_in      (data_in),
        .start_reading(start_reading),
        .busy         (busy)
    );

    typedef struct {
        int            cyc;
        logic [1:0]    ctrl;
        logic          rd;
        logic [KW-1:0] k;
        logic [DW-1:0] d;
    } cmd_t;

    cmd_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   pulses_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    // Inputs reach the debouncer two edges after being sampled; a button level is
    // accepted after DB consecutive edges of disagreement; a press is accepted only
    // when no command is outstanding and every button has been released since.
    logic [3:0]    bh1 = '0, bh2 = '0;
    logic [KW-1:0] kh1 = '0, kh2 = '0;
    logic [DW-1:0] dh1 = '0, dh2 = '0;
    logic [3:0]    m_deb = '0;
    int            m_run [4];
    logic          m_armed = 1'b1;
    logic          m_issuing = 1'b0;
    logic          m_busy = 1'b0;
    logic [KW-1:0] m_key = '0;
    logic [DW-1:0] m_data = '0;

    initial begin
        cmd_t c;
        for (int b = 0; b < 4; b++) m_run[b] = 0;
        forever begin
            @(posedge clk);
            if (!async_nreset) begin
                bh1 = '0; bh2 = '0; kh1 = '0; kh2 = '0; dh1 = '0; dh2 = '0;
                m_deb = '0;
                for (int b = 0; b < 4; b++) m_run[b] = 0;
                m_armed = 1'b1; m_issuing = 1'b0; m_busy = 1'b0;
                m_key = '0; m_data = '0;
                exp_q.delete();
            end else begin
                if (m_issuing) begin
                    m_issuing = 1'b0;
                end else if (!m_armed) begin
                    if (m_deb == 4'b0) m_armed = 1'b1;
                end else if (m_deb != 4'b0) begin
                    m_armed = 1'b0;
                    if (cmd_enable) begin
                        m_issuing = 1'b1;
                        m_key  = kh2;
                        m_data = dh2;
                        c.cyc = cyc + 1;
                        c.k = kh2;
                        c.d = dh2;
                        c.rd = 1'b0;
                        if (m_deb[3])      begin c.ctrl = 2'd0; c.rd = 1'b1; end
                        else if (m_deb[2]) c.ctrl = 2'd3;
                        else if (m_deb[0]) c.ctrl = 2'd1;
                        else               c.ctrl = 2'd2;
                        exp_q.push_back(c);
                    end
                end
                m_busy = !m_armed;
                for (int b = 0; b < 4; b++) begin
                    if (bh2[b] != m_deb[b]) begin
                        m_run[b] = m_run[b] + 1;
                        if (m_run[b] == DB) begin
                            m_deb[b] = ~m_deb[b];
                            m_run[b] = 0;
                        end
                    end else begin
                        m_run[b] = 0;
                    end
                end
                bh2 = bh1; bh1 = {btn_read, btn_clr, btn_incr, btn_load};
                kh2 = kh1; kh1 = sw_key;
                dh2 = dh1; dh1 = sw_data;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        cmd_t c;
        forever begin
            @(negedge clk);
            if (!async_nreset) begin
                tests++;
                if (ctrl !== 2'd0 || key !== '0 || data_in !== '0 || start_reading !== 1'b0 || busy !== 1'b0) begin
                    fails++;
                    $display("FAIL reset_state: ctrl=%0d key=%h data=%h rd=%b busy=%b, required all 0",
                             ctrl, key, data_in, start_reading, busy);
                end
            end else begin
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    c = exp_q.pop_front();
                    tests++; fails++;
                    $display("FAIL missing_cmd: nothing at cycle %0d, required ctrl=%0d rd=%b",
                             c.cyc, c.ctrl, c.rd);
                end
                if (ctrl !== 2'd0 || start_reading !== 1'b0) begin
                    pulses_seen++;
                    tests++;
                    if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                        fails++;
                        $display("FAIL unexpected_cmd: cycle %0d ctrl=%0d rd=%b, required no command",
                                 cyc, ctrl, start_reading);
                    end else begin
                        c = exp_q.pop_front();
                        if (ctrl !== c.ctrl || start_reading !== c.rd || key !== c.k || data_in !== c.d) begin
                            fails++;
                            $display("FAIL cmd_content: got ctrl=%0d rd=%b key=%h data=%h, required ctrl=%0d rd=%b key=%h data=%h",
                                     ctrl, start_reading, key, data_in, c.ctrl, c.rd, c.k, c.d);
                        end else begin
                            $display("[TB] cycle %0d cmd ctrl=%0d rd=%b key=%h data=%h ok",
                                     cyc, ctrl, start_reading, key, data_in);
                        end
                    end
                end
                tests++;
                if (busy !== m_busy) begin
                    fails++;
                    $display("FAIL busy: cycle %0d got %b, required %b", cyc, busy, m_busy);
                end
                tests++;
                if (key !== m_key || data_in !== m_data) begin
                    fails++;
                    $display("FAIL key_data_hold: cycle %0d got %h/%h, required %h/%h",
                             cyc, key, data_in, m_key, m_data);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic set_btn(input logic [3:0] b);
        {btn_read, btn_clr, btn_incr, btn_load} = b;
    endtask

    task automatic check(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    initial begin
        int found;
        int p0;
        int saw;
        logic [3:0] b;

        // Reset with random inputs
        set_btn(4'($urandom_range(0, 15)));
        sw_key  = KW'($urandom);
        sw_data = DW'($urandom);
        step(3);
        set_btn(4'b0);
        step(1);
        async_nreset = 1'b1;
        step(10);

        // Single LOAD with exact latency
        sw_key = 4'hA; sw_data = 8'h3C;
        set_btn(4'b0001);
        found = 0;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            if (found == 0 && ctrl == 2'd1) found = k;
        end
        check("load_latency", found, DB + 3);
        check("load_key", int'(key), 32'hA);
        check("load_data", int'(data_in), 32'h3C);
        step(10);
        set_btn(4'b0);
        step(12);

        // Glitching INCR never accepted
        saw = 0;
        for (int i = 0; i < 6; i++) begin
            btn_incr = ~btn_incr;
            for (int j = 0; j < 2; j++) begin
                step(1);
                if (ctrl != 2'd0 || busy) saw = 1;
            end
        end
        btn_incr = 1'b0;
        for (int j = 0; j < 12; j++) begin
            step(1);
            if (ctrl != 2'd0 || busy) saw = 1;
        end
        check("glitch_no_cmd", saw, 0);

        // CLR and LOAD together, then INCR
        p0 = pulses_seen;
        sw_key = 4'h5; sw_data = 8'hC3;
        set_btn(4'b0101);
        step(10);
        btn_load = 1'b0;
        step(10);
        check("clr_priority_one_pulse", pulses_seen - p0, 1);
        btn_clr = 1'b0;
        step(10);
        btn_incr = 1'b1;
        step(12);
        btn_incr = 1'b0;
        step(12);
        check("incr_after_clr", pulses_seen - p0, 2);

        // Disabled READ is consumed, re-press issues
        p0 = pulses_seen;
        cmd_enable = 1'b0;
        btn_read = 1'b1;
        step(10);
        check("disabled_busy", int'(busy), 1);
        cmd_enable = 1'b1;
        step(5);
        check("enable_while_held", pulses_seen - p0, 0);
        btn_read = 1'b0;
        step(10);
        btn_read = 1'b1;
        step(12);
        btn_read = 1'b0;
        step(12);
        check("read_repress", pulses_seen - p0, 1);

        // Reset during the ISSUE cycle of a LOAD
        sw_key = 4'h7; sw_data = 8'h81;
        btn_load = 1'b1;
        found = 0;
        for (int k = 1; k <= 20 && found == 0; k++) begin
            step(1);
            if (ctrl == 2'd1) found = k;
        end
        check("pre_reset_load_seen", (found != 0) ? 1 : 0, 1);
        async_nreset = 1'b0;
        #1;
        check("async_reset_ctrl", int'(ctrl), 0);
        check("async_reset_busy", int'(busy), 0);
        step(3);
        async_nreset = 1'b1;
        found = 0;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            if (found == 0 && ctrl == 2'd1) found = k;
        end
        check("post_reset_latency", found, DB + 3);
        btn_load = 1'b0;
        step(12);

        // Randomized traffic against the model
        for (int it = 0; it < 250; it++) begin
            case ($urandom_range(0, 3))
                0:       b = 4'b0;
                1:       b = 4'(1 << $urandom_range(0, 3));
                default: b = 4'($urandom_range(0, 15));
            endcase
            set_btn(b);
            sw_key     = KW'($urandom);
            sw_data    = DW'($urandom);
            cmd_enable = ($urandom_range(0, 4) != 0);
            step($urandom_range(1, 12));
        end
        set_btn(4'b0);
        cmd_enable = 1'b1;
        step(20);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/buffer_command_frontend.md
Name: buffer_command_frontend

Overview:
Upstream command front-end for the associative key/data buffer. It synchronizes and debounces four raw push-buttons and samples the key/data switches. Each debounced press becomes exactly one single-cycle command: ctrl LOAD/INCR/CLR with stable key/data, or a start_reading pulse. Its outputs connect directly to the buffer's ctrl, key, data_in and start_reading inputs.

Parameters:
DATA_WIDTH, 8, width of sw_data / data_in
KEY_WIDTH, 4, width of sw_key / key
DEBOUNCE_CYCLES, 500000, number of consecutive stable cycles needed to accept a button level change (must be >= 2)

Ports:
clk  input  1  clock
async_nreset  input  1  reset; asynchronous, active-low
btn_load  input  1  raw asynchronous button, active-high
btn_incr  input  1  raw asynchronous button, active-high
btn_clr  input  1  raw asynchronous button, active-high
btn_read  input  1  raw asynchronous button, active-high
sw_key  input  KEY_WIDTH  raw key switches
sw_data  input  DATA_WIDTH  raw data switches
cmd_enable  input  1  synchronous; 0 = presses are consumed but not issued
ctrl  output  2  0 NONE, 1 LOAD, 2 INCR, 3 CLR; registered
key  output  KEY_WIDTH  registered key for the issued command
data_in  output  DATA_WIDTH  registered data for the issued command
start_reading  output  1  registered single-cycle pulse
busy  output  1  high when FSM is not IDLE

Behaviour:
- Reset (async, active-low): ctrl=0, key=0, data_in=0, start_reading=0, busy=0, FSM=IDLE. All synchronizer flops, debounced levels and counters are cleared. Reset takes effect immediately, including mid-pulse.
- Synchronization: each button and every switch bit passes through a fixed 2-flop synchronizer.
- Debounce, per button:
  - Counter clears whenever the synchronized level equals the debounced level.
  - Otherwise the counter increments each cycle.
  - On the edge where counter==DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level toggles and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES produces no change.
- FSM states: IDLE, ISSUE, WAIT_RELEASE.
  - IDLE: if any debounced button is high and cmd_enable=1, go to ISSUE. Also latch the synchronized switches into key/data_in and register the command.
  - IDLE: if any debounced button is high and cmd_enable=0, go to WAIT_RELEASE with no command.
  - ISSUE: lasts exactly one cycle. ctrl holds the code, or start_reading=1. Next state is WAIT_RELEASE, and ctrl/start_reading return to 0.
  - WAIT_RELEASE: stay until all four debounced levels are 0, then go to IDLE. Holding a button therefore never repeats a command.
- Priority when several debounced buttons are high in the same cycle: READ > CLR > LOAD > INCR. Only one command is issued, and none of the others is queued.
- Latency: raw rise sampled at edge e0 -> debounced high after e(1+DEBOUNCE_CYCLES) -> ctrl/start_reading valid for the one cycle following edge e(2+DEBOUNCE_CYCLES).
- key/data_in: hold their last latched value after the pulse. They change only on entry to ISSUE.
- During a READ command: ctrl stays NONE, and key/data_in are still latched.
- After reset with a button held: the press is debounced afresh and issues one command.

Test Plan:
- Reset: drive async_nreset=0 with buttons/switches random -> all outputs 0 immediately and while held.
- DEBOUNCE_CYCLES=4; sw_key=4'hA, sw_data=8'h3C; btn_load rises before e0 and is held 30 cycles -> ctrl=1, key=4'hA, data_in=8'h3C only in the cycle after e6. ctrl stays 0 thereafter, and key/data stay A/3C.
- btn_incr toggles every 2 cycles for 12 cycles, then held low -> no ctrl pulse, busy stays 0.
- btn_clr and btn_load rise in the same cycle and are held 10 cycles, then only btn_load is released -> exactly one ctrl=3 and nothing more. Release btn_clr, wait 10, press btn_incr -> one ctrl=2.
- cmd_enable=0, btn_read pressed 10 cycles -> no start_reading, busy=1 while held. Set cmd_enable=1 with btn_read still held -> no pulse. Release, then press again -> one start_reading pulse with ctrl=0.
- Assert reset during the ISSUE cycle of a LOAD -> ctrl drops to 0 asynchronously. Deassert with btn_load still held -> one new ctrl=1 after the full debounce latency.
